hba_arbiter: RTL and testbench
==============================

HBA_ARBITER -- requirements
Module: hba_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of bus masters (legal range 2..8).
REQ-002 Parameter DBUS_WIDTH, default 8, data bus width.
REQ-003 Parameter ADDR_WIDTH, default 12, full HBA address width (4-bit peripheral slot plus 8-bit register).
REQ-004 Parameter TIMEOUT_CYCLES, default 255, watchdog limit; used only when HBA_ARB_TIMEOUT_EN is defined.
REQ-005 Clocking and reset SHALL be: one clock, and reset is asynchronous and active-low.
REQ-006 hba_clk  in  1  bus clock; all state changes on its rising edge.
REQ-007 hba_reset  in  1  asynchronous, active-low reset.
REQ-008 hba_mrequest  in  NUM_MASTERS  per-master bus request.
REQ-009 hba_abus_m  in  NUM_MASTERS*ADDR_WIDTH  packed master addresses; master i occupies slice i.
REQ-010 hba_rnw_m  in  NUM_MASTERS  per-master read-not-write.
REQ-011 hba_select_m  in  NUM_MASTERS  per-master transfer-in-progress.
REQ-012 hba_dbus_m  in  NUM_MASTERS*DBUS_WIDTH  packed master write data.
REQ-013 hba_xferack  in  1  slave transfer-complete strobe.
REQ-014 hba_mgrant  out  NUM_MASTERS  one-hot grant, all zero when idle.
REQ-015 hba_abus, hba_rnw, hba_select, hba_dbus_wr  out  ADDR_WIDTH/1/1/DBUS_WIDTH  muxed slave-side bus.
REQ-016 hba_arb_timeout  out  1  one-cycle watchdog pulse (tied 0 when the feature is excluded).

Function
REQ-017 The FSM SHALL have states IDLE, GRANTED, RELEASE.
REQ-018 IDLE: if any request is set, select the winner round-robin starting at index (last_owner+1) mod NUM_MASTERS; assert its grant bit on the next edge; go to GRANTED.
REQ-019 GRANTED: hold the grant unchanged while the owner's hba_mrequest stays high, regardless of other requests.
REQ-020 GRANTED: when the owner's hba_mrequest is low, clear hba_mgrant on the next edge, record last_owner, and go to RELEASE.
REQ-021 RELEASE lasts exactly one cycle with no grant (bus turnaround), then the FSM goes to IDLE.
REQ-022 Minimum request-to-grant latency is 1 cycle; handover between two masters costs 2 dead cycles.
REQ-023 Bus outputs are combinational AND-OR of master slices gated by hba_mgrant; all four are zero whenever no grant is set.
REQ-024 A master's request and select while it is not granted SHALL have no effect on the bus outputs.
REQ-025 If requests appear in RELEASE, they are arbitrated in the following IDLE cycle; none is lost.
REQ-026 hba_mgrant SHALL never have more than one bit set.

Reset
REQ-027 On reset assertion, immediately: state=IDLE, hba_mgrant=0, last_owner=NUM_MASTERS-1 (master 0 wins the first arbitration), timeout counter=0, hba_arb_timeout=0.
REQ-028 Reset mid-transfer SHALL drop the grant asynchronously; bus outputs go to zero in the same cycle.

Configuration
REQ-029 With HBA_ARB_TIMEOUT_EN defined: a counter increments every GRANTED cycle in which the owner's select is high and hba_xferack is low; it clears on hba_xferack or on leaving GRANTED.
REQ-030 With HBA_ARB_TIMEOUT_EN defined: when the count reaches TIMEOUT_CYCLES, on the next edge the FSM clears the grant, pulses hba_arb_timeout for 1 cycle, records last_owner, and goes to RELEASE.
REQ-031 Without HBA_ARB_TIMEOUT_EN: no counter exists, hba_arb_timeout is constant 0, and the grant is held indefinitely.

Structure
REQ-032 The shared package hba_pkg SHALL hold the state encoding constants (IDLE/GRANTED/RELEASE) and the peripheral/register address width constants.
REQ-033 The round-robin priority picker SHALL be a combinational sub-module hba_rr_pick (inputs: request vector, last_owner; output: one-hot winner plus valid).

Verification
REQ-034 Single master: master0 requests at cycle 10 -> hba_mgrant=01 at cycle 11; abus=0x100 from master0 appears on hba_abus while granted.
REQ-035 Contention: both masters request at cycle 5 after reset -> master0 granted; master0 drops its request -> grant 00 for 2 cycles -> master1 granted.
REQ-036 Fairness: both masters hold requests continuously and release after each xferack -> grant alternates 01,10,01,10; no master is granted twice in a row.
REQ-037 Isolation: master1 drives select=1 and abus=0xFFF while master0 is granted with abus=0x203 -> hba_abus=0x203 and hba_select follows master0 only.
REQ-038 Async reset: hba_reset driven low mid-cycle while granted -> hba_mgrant=0 and hba_select=0 before the next edge; after release, master0 wins first.
REQ-039 Timeout (HBA_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): owner holds select with no xferack -> grant drops after the 4th counted cycle, hba_arb_timeout pulses high for 1 cycle, the other requester is granted 2 cycles later.

Source files
------------

// File: rtl/hba_pkg.sv
// Shared HBA arbiter definitions: address field widths, FSM state encoding and the grant-to-index helper.
package hba_pkg;

  localparam int HBA_PERIPH_WIDTH = 4;
  localparam int HBA_REG_WIDTH    = 8;
  localparam int HBA_ADDR_WIDTH   = HBA_PERIPH_WIDTH + HBA_REG_WIDTH;
  localparam int HBA_MAX_MASTERS  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Index of the set bit in a one-hot grant; zero when no bit is set.
  function automatic int onehot_idx(input logic [HBA_MAX_MASTERS-1:0] v);
    onehot_idx = 0;
    for (int i = 0; i < HBA_MAX_MASTERS; i++) begin
      if (v[i]) onehot_idx = i;
    end
  endfunction

endpackage

// File: rtl/hba_rr_pick.sv
// Combinational round-robin picker; the search starts at (last_owner+1) mod NUM_MASTERS.
// Zero latency; no backpressure, the winner is simply a function of the current requests.
module hba_rr_pick
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last_owner,
  output logic [NUM_MASTERS-1:0] winner,
  output logic                   vld
);

  // Distance d is how far master j sits after last_owner; closest requester wins.
  always_comb begin
    winner = '0;
    vld    = 1'b0;
    for (int d = 0; d < NUM_MASTERS; d++) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (!vld && req[j] &&
            (((j + NUM_MASTERS - 1 - int'(last_owner)) % NUM_MASTERS) == d)) begin
          winner[j] = 1'b1;
          vld       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hba_arbiter.sv
// HBA bus arbiter: round-robin grant, one turnaround cycle, 1-cycle request-to-grant; optional watchdog under HBA_ARB_TIMEOUT_EN.
// The owner keeps the bus while it requests; bus outputs are a grant-gated AND-OR mux, zero when idle.
module hba_arbiter
  import hba_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DBUS_WIDTH     = 8,
  parameter int ADDR_WIDTH     = HBA_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             hba_clk,
  input  logic                             hba_reset,
  input  logic [NUM_MASTERS-1:0]           hba_mrequest,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] hba_abus_m,
  input  logic [NUM_MASTERS-1:0]           hba_rnw_m,
  input  logic [NUM_MASTERS-1:0]           hba_select_m,
  input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] hba_dbus_m,
  input  logic                             hba_xferack,
  output logic [NUM_MASTERS-1:0]           hba_mgrant,
  output logic [ADDR_WIDTH-1:0]            hba_abus,
  output logic                             hba_rnw,
  output logic                             hba_select,
  output logic [DBUS_WIDTH-1:0]            hba_dbus_wr,
  output logic                             hba_arb_timeout
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_t                 state;
  logic [IDX_W-1:0]           last_owner;
  logic [NUM_MASTERS-1:0]     pick_winner;
  logic                       pick_vld;
  logic                       owner_req;
  logic                       tmo_hit;
  logic                       release_now;
  logic [HBA_MAX_MASTERS-1:0] grant_ext;

  hba_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr_pick (
    .req        (hba_mrequest),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .vld        (pick_vld)
  );

  assign owner_req   = |(hba_mrequest & hba_mgrant);
  assign grant_ext   = HBA_MAX_MASTERS'(hba_mgrant);
  assign release_now = (state == ST_GRANTED) && (!owner_req || tmo_hit);

`ifdef HBA_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             owner_sel;
  logic             tmo_pulse;

  assign owner_sel       = |(hba_select_m & hba_mgrant);
  assign tmo_hit         = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign hba_arb_timeout = tmo_pulse;

  // Counts stalled owner cycles; any ack or the end of the tenure restarts it.
  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      tmo_cnt <= '0;
    end else if (state != ST_GRANTED || hba_xferack || release_now) begin
      tmo_cnt <= '0;
    end else if (owner_sel) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_xferack;

  assign unused_xferack  = hba_xferack;
  assign tmo_hit         = 1'b0;
  assign hba_arb_timeout = 1'b0;
`endif

  always_ff @(posedge hba_clk or negedge hba_reset) begin
    if (!hba_reset) begin
      state      <= ST_IDLE;
      hba_mgrant <= '0;
      last_owner <= IDX_W'(NUM_MASTERS - 1);
`ifdef HBA_ARB_TIMEOUT_EN
      tmo_pulse  <= 1'b0;
`endif
    end else begin
`ifdef HBA_ARB_TIMEOUT_EN
      tmo_pulse <= release_now && owner_req;
`endif
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            hba_mgrant <= pick_winner;
            state      <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (release_now) begin
            hba_mgrant <= '0;
            last_owner <= IDX_W'(onehot_idx(grant_ext));
            state      <= ST_RELEASE;
          end
        end
        ST_RELEASE: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hba_abus    = '0;
    hba_rnw     = 1'b0;
    hba_select  = 1'b0;
    hba_dbus_wr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      hba_abus    = hba_abus    | (hba_abus_m[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{hba_mgrant[i]}});
      hba_dbus_wr = hba_dbus_wr | (hba_dbus_m[i*DBUS_WIDTH +: DBUS_WIDTH] & {DBUS_WIDTH{hba_mgrant[i]}});
      hba_rnw     = hba_rnw     | (hba_rnw_m[i]    & hba_mgrant[i]);
      hba_select  = hba_select  | (hba_select_m[i] & hba_mgrant[i]);
    end
  end

endmodule

// File: tb/tb_hba_arbiter.sv
// Directed bench for hba_arbiter: reset, single master, contention, fairness, isolation, async reset, watchdog.
module tb_hba_arbiter;

  localparam int NM = 2;
  localparam int DW = 8;
  localparam int AW = 12;

  logic          hba_clk = 1'b0;
  logic          hba_reset = 1'b0;
  logic [NM-1:0] hba_mrequest;
  logic [NM*AW-1:0] hba_abus_m;
  logic [NM-1:0] hba_rnw_m;
  logic [NM-1:0] hba_select_m;
  logic [NM*DW-1:0] hba_dbus_m;
  logic          hba_xferack;
  logic [NM-1:0] hba_mgrant;
  logic [AW-1:0] hba_abus;
  logic          hba_rnw;
  logic          hba_select;
  logic [DW-1:0] hba_dbus_wr;
  logic          hba_arb_timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 hba_clk = ~hba_clk;

  hba_arbiter #(
    .NUM_MASTERS    (NM),
    .DBUS_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .hba_clk         (hba_clk),
    .hba_reset       (hba_reset),
    .hba_mrequest    (hba_mrequest),
    .hba_abus_m      (hba_abus_m),
    .hba_rnw_m       (hba_rnw_m),
    .hba_select_m    (hba_select_m),
    .hba_dbus_m      (hba_dbus_m),
    .hba_xferack     (hba_xferack),
    .hba_mgrant      (hba_mgrant),
    .hba_abus        (hba_abus),
    .hba_rnw         (hba_rnw),
    .hba_select      (hba_select),
    .hba_dbus_wr     (hba_dbus_wr),
    .hba_arb_timeout (hba_arb_timeout)
  );

  task automatic step();
    @(posedge hba_clk);
    #1;
  endtask

  task automatic clear_inputs();
    hba_mrequest = '0;
    hba_abus_m   = '0;
    hba_rnw_m    = '0;
    hba_select_m = '0;
    hba_dbus_m   = '0;
    hba_xferack  = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    hba_reset = 1'b0;
    step();
    step();
    hba_reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    hba_reset    = 1'b0;
    hba_mrequest = 2'b11;
    hba_select_m = 2'b11;
    hba_rnw_m    = 2'b11;
    hba_abus_m   = {12'h200, 12'h100};
    hba_dbus_m   = {8'h22, 8'h11};
    step();
    step();
    n_cmp++; if (hba_mgrant !== 2'b00) begin n_err++; $display("FAIL reset_grant got %b want 00", hba_mgrant); end
    n_cmp++; if (hba_abus !== 12'h000) begin n_err++; $display("FAIL reset_abus got %h want 000", hba_abus); end
    n_cmp++; if ({hba_rnw, hba_select} !== 2'b00) begin n_err++; $display("FAIL reset_rnw_sel got %b want 00", {hba_rnw, hba_select}); end
    n_cmp++; if (hba_dbus_wr !== 8'h00) begin n_err++; $display("FAIL reset_dbus got %h want 00", hba_dbus_wr); end
    n_cmp++; if (hba_arb_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", hba_arb_timeout); end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    hba_mrequest = 2'b01;
    hba_abus_m[0 +: AW] = 12'h100;
    hba_select_m = 2'b01;
    hba_rnw_m    = 2'b01;
    hba_dbus_m[0 +: DW] = 8'hA5;
    #1;
    n_cmp++; if (hba_abus !== 12'h000) begin n_err++; $display("FAIL single_pregrant_abus got %h want 000", hba_abus); end
    step();
    n_cmp++; if (hba_mgrant !== 2'b01) begin n_err++; $display("FAIL single_grant got %b want 01", hba_mgrant); end
    n_cmp++; if (hba_abus !== 12'h100) begin n_err++; $display("FAIL single_abus got %h want 100", hba_abus); end
    n_cmp++; if ({hba_rnw, hba_select} !== 2'b11) begin n_err++; $display("FAIL single_rnw_sel got %b want 11", {hba_rnw, hba_select}); end
    n_cmp++; if (hba_dbus_wr !== 8'hA5) begin n_err++; $display("FAIL single_dbus got %h want a5", hba_dbus_wr); end
    step();
    n_cmp++; if (hba_mgrant !== 2'b01) begin n_err++; $display("FAIL single_hold got %b want 01", hba_mgrant); end
    hba_mrequest = 2'b00;
    step();
    n_cmp++; if (hba_mgrant !== 2'b00) begin n_err++; $display("FAIL single_release got %b want 00", hba_mgrant); end
    n_cmp++; if (hba_abus !== 12'h000) begin n_err++; $display("FAIL single_release_abus got %h want 000", hba_abus); end
  endtask

  task automatic test_contention();
    apply_reset();
    hba_mrequest = 2'b11;
    step();
    n_cmp++; if (hba_mgrant !== 2'b01) begin n_err++; $display("FAIL cont_first got %b want 01", hba_mgrant); end
    step(); step(); step();
    n_cmp++; if (hba_mgrant !== 2'b01) begin n_err++; $display("FAIL cont_hold got %b want 01", hba_mgrant); end
    hba_mrequest = 2'b10;
    step();
    n_cmp++; if (hba_mgrant !== 2'b00) begin n_err++; $display("FAIL cont_dead1 got %b want 00", hba_mgrant); end
    step();
    n_cmp++; if (hba_mgrant !== 2'b00) begin n_err++; $display("FAIL cont_dead2 got %b want 00", hba_mgrant); end
    step();
    n_cmp++; if (hba_mgrant !== 2'b10) begin n_err++; $display("FAIL cont_handover got %b want 10", hba_mgrant); end
  endtask

  task automatic test_fairness();
    logic [NM-1:0] exp_seq [4];
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    apply_reset();
    hba_mrequest = 2'b11;
    step();
    n_cmp++; if (hba_mgrant !== exp_seq[0]) begin n_err++; $display("FAIL fair_grant0 got %b want %b", hba_mgrant, exp_seq[0]); end
    for (int g = 1; g < 4; g++) begin
      hba_xferack  = 1'b1;
      hba_mrequest = 2'b11 & ~exp_seq[g-1];
      step();
      hba_xferack  = 1'b0;
      hba_mrequest = 2'b11;
      n_cmp++; if (hba_mgrant !== 2'b00) begin n_err++; $display("FAIL fair_turnaround%0d got %b want 00", g, hba_mgrant); end
      step();
      step();
      n_cmp++; if (hba_mgrant !== exp_seq[g]) begin n_err++; $display("FAIL fair_grant%0d got %b want %b", g, hba_mgrant, exp_seq[g]); end
    end
  endtask

  task automatic test_isolation();
    apply_reset();
    hba_mrequest = 2'b11;
    hba_abus_m   = {12'hFFF, 12'h203};
    hba_dbus_m   = {8'hFF, 8'h3C};
    hba_select_m = 2'b10;
    hba_rnw_m    = 2'b01;
    #1;
    n_cmp++; if (hba_select !== 1'b0) begin n_err++; $display("FAIL iso_idle_select got %b want 0", hba_select); end
    step();
    n_cmp++; if (hba_mgrant !== 2'b01) begin n_err++; $display("FAIL iso_grant got %b want 01", hba_mgrant); end
    n_cmp++; if (hba_abus !== 12'h203) begin n_err++; $display("FAIL iso_abus got %h want 203", hba_abus); end
    n_cmp++; if (hba_dbus_wr !== 8'h3C) begin n_err++; $display("FAIL iso_dbus got %h want 3c", hba_dbus_wr); end
    n_cmp++; if ({hba_rnw, hba_select} !== 2'b10) begin n_err++; $display("FAIL iso_rnw_sel got %b want 10", {hba_rnw, hba_select}); end
    hba_select_m = 2'b11;
    #1;
    n_cmp++; if (hba_select !== 1'b1) begin n_err++; $display("FAIL iso_sel_follow1 got %b want 1", hba_select); end
    hba_select_m = 2'b10;
    #1;
    n_cmp++; if (hba_select !== 1'b0) begin n_err++; $display("FAIL iso_sel_follow0 got %b want 0", hba_select); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    hba_mrequest = 2'b10;
    hba_select_m = 2'b10;
    hba_abus_m[AW +: AW] = 12'h0AB;
    step();
    n_cmp++; if (hba_mgrant !== 2'b10) begin n_err++; $display("FAIL arst_pregrant got %b want 10", hba_mgrant); end
    #2;
    hba_reset = 1'b0;
    #1;
    n_cmp++; if (hba_mgrant !== 2'b00) begin n_err++; $display("FAIL arst_grant got %b want 00", hba_mgrant); end
    n_cmp++; if ({hba_select, hba_abus} !== 13'h0) begin n_err++; $display("FAIL arst_bus got %h want 0", {hba_select, hba_abus}); end
    hba_mrequest = 2'b11;
    step();
    hba_reset = 1'b1;
    step();
    n_cmp++; if (hba_mgrant !== 2'b01) begin n_err++; $display("FAIL arst_first_winner got %b want 01", hba_mgrant); end
  endtask

  task automatic test_timeout();
    apply_reset();
    hba_mrequest = 2'b11;
    hba_select_m = 2'b01;
    step();
    n_cmp++; if (hba_mgrant !== 2'b01) begin n_err++; $display("FAIL tmo_grant got %b want 01", hba_mgrant); end
`ifdef HBA_ARB_TIMEOUT_EN
    step(); step(); step(); step();
    n_cmp++; if ({hba_mgrant, hba_arb_timeout} !== 3'b010) begin n_err++; $display("FAIL tmo_count4 got %b want 010", {hba_mgrant, hba_arb_timeout}); end
    step();
    n_cmp++; if ({hba_mgrant, hba_arb_timeout} !== 3'b001) begin n_err++; $display("FAIL tmo_fire got %b want 001", {hba_mgrant, hba_arb_timeout}); end
    step();
    n_cmp++; if ({hba_mgrant, hba_arb_timeout} !== 3'b000) begin n_err++; $display("FAIL tmo_pulse_end got %b want 000", {hba_mgrant, hba_arb_timeout}); end
    step();
    n_cmp++; if (hba_mgrant !== 2'b10) begin n_err++; $display("FAIL tmo_next_owner got %b want 10", hba_mgrant); end
`else
    begin
      logic seen_change;
      seen_change = 1'b0;
      for (int c = 0; c < 20; c++) begin
        step();
        if (hba_arb_timeout !== 1'b0 || hba_mgrant !== 2'b01) seen_change = 1'b1;
      end
      n_cmp++; if (seen_change !== 1'b0) begin n_err++; $display("FAIL tmo_disabled_hold got %b want 0", seen_change); end
      n_cmp++; if ({hba_mgrant, hba_arb_timeout} !== 3'b010) begin n_err++; $display("FAIL tmo_disabled_final got %b want 010", {hba_mgrant, hba_arb_timeout}); end
    end
`endif
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_isolation();
    test_async_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
